// File: rtl/mult_accumulate_stage.sv
// Purpose : burst dot-product of 8-bit unsigned operand pairs through the 8x8 array multiplier.
// Latency : the result is valid in the second cycle after the cycle that accepts the last pair.
// Backpr. : in_ready is high only while collecting pairs; the result is held until out_ready.

// Combinational 8x8 unsigned array multiplier: one shifted partial product per multiplier bit.
module array_mult_eight_bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // Sum the shifted, gated partial products.
    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + ({8'd0, a} << i);
            end
        end
    end

endmodule

module mult_accumulate_stage #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [15:0]      prod;
    logic [15:0]      prod_r;
    logic             prod_v;
    logic             accept;
    logic [ACC_W:0]   sum_ext;

    array_mult_eight_bit u_mult (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign accept  = in_valid && in_ready;
    // One extra bit on the adder exposes the carry out of the accumulator's top bit.
    assign sum_ext = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod_r};
    assign acc_out = acc;

    // Next-state and handshake outputs; the product pipeline stage is flushed in DRAIN.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (count == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture products on accept, fold the previous product into the sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            prod_r   <= '0;
            prod_v   <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_r <= prod;
                count  <= count - LEN_W'(1);
            end
            if ((state == IDLE) && start) begin
                count    <= len;
                acc      <= '0;
                overflow <= 1'b0;
            end else if (prod_v) begin
                acc      <= sum_ext[ACC_W-1:0];
                overflow <= overflow | sum_ext[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_mult_accumulate_stage.sv
module tb_mult_accumulate_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_ready;

    logic        in_ready24, out_valid24, ovf24, busy24;
    logic [23:0] acc24;
    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] acc16;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    mult_accumulate_stage #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready24), .a(a), .b(b),
        .out_valid(out_valid24), .out_ready(out_ready), .acc_out(acc24),
        .overflow(ovf24), .busy(busy24)
    );

    mult_accumulate_stage #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
        .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16),
        .overflow(ovf16), .busy(busy16)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the burst held in qa/qb with random idle gaps and a result hold-off, checking both widths.
    task automatic do_burst(input string name, input int min_gap, input int max_gap, input int hold);
        int          n;
        longint      sum;
        logic [23:0] e24;
        logic [15:0] e16;
        logic        o24, o16;
        n   = qa.size();
        sum = 0;
        foreach (qa[i]) sum += longint'(qa[i]) * longint'(qb[i]);
        e24 = sum[23:0];
        e16 = sum[15:0];
        o24 = (sum > 64'hFF_FFFF);
        o16 = (sum > 64'hFFFF);

        start = 1'b1;
        len   = n[7:0];
        step();
        start = 1'b0;
        if (n == 0) begin
            checks++; if (in_ready24 !== 1'b0 || in_ready16 !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b/%b want 0", name, in_ready24, in_ready16); end
        end else begin
            for (int i = 0; i < n; i++) begin
                int g;
                g = $urandom_range(max_gap, min_gap);
                in_valid = 1'b0;
                repeat (g) step();
                in_valid = 1'b1;
                a = qa[i][7:0];
                b = qb[i][7:0];
                checks++; if (in_ready24 !== 1'b1 || in_ready16 !== 1'b1) begin errors++; $display("FAIL %s in_ready pair %0d: got %b/%b want 1", name, i, in_ready24, in_ready16); end
                step();
            end
            in_valid = 1'b0;
            checks++; if (out_valid24 !== 1'b0 || in_ready24 !== 1'b0 || busy24 !== 1'b1) begin errors++; $display("FAIL %s drain: got ov=%b ir=%b busy=%b want 0 0 1", name, out_valid24, in_ready24, busy24); end
            step();
        end
        checks++; if (out_valid24 !== 1'b1 || out_valid16 !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b/%b want 1", name, out_valid24, out_valid16); end
        checks++; if (acc24 !== e24 || ovf24 !== o24) begin errors++; $display("FAIL %s acc24: got %0d ovf %b want %0d ovf %b", name, acc24, ovf24, e24, o24); end
        checks++; if (acc16 !== e16 || ovf16 !== o16) begin errors++; $display("FAIL %s acc16: got %0d ovf %b want %0d ovf %b", name, acc16, ovf16, e16, o16); end
        for (int h = 0; h < hold; h++) begin
            step();
            checks++; if (out_valid24 !== 1'b1 || acc24 !== e24 || ovf24 !== o24) begin errors++; $display("FAIL %s hold %0d: got ov=%b acc=%0d want 1 %0d", name, h, out_valid24, acc24, e24); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid24 !== 1'b0 || busy24 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL %s release: got ov=%b busy=%b/%b want 0 0", name, out_valid24, busy24, busy16); end
        checks++; if (acc24 !== e24 || acc16 !== e16) begin errors++; $display("FAIL %s acc kept: got %0d/%0d want %0d/%0d", name, acc24, acc16, e24, e16); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (in_ready24 !== 1'b0 || out_valid24 !== 1'b0 || busy24 !== 1'b0) begin errors++; $display("FAIL reset ctl24: got %b %b %b want 0 0 0", in_ready24, out_valid24, busy24); end
        checks++; if (acc24 !== 24'd0 || ovf24 !== 1'b0 || acc16 !== 16'd0 || ovf16 !== 1'b0) begin errors++; $display("FAIL reset acc: got %0d %b %0d %b want 0", acc24, ovf24, acc16, ovf16); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        qa = '{3, 255, 1};
        qb = '{4, 255, 0};
        do_burst("basic", 0, 0, 0);
        checks++; if (acc24 !== 24'd65037) begin errors++; $display("FAIL basic const: got %0d want 65037", acc24); end
    endtask

    task automatic test_zero_len();
        qa = {};
        qb = {};
        do_burst("zero_len", 0, 0, 0);
    endtask

    task automatic test_wrap();
        qa = '{255, 255};
        qb = '{255, 255};
        do_burst("wrap", 0, 0, 0);
        checks++; if (acc16 !== 16'd64514 || ovf16 !== 1'b1) begin errors++; $display("FAIL wrap const: got %0d ovf %b want 64514 ovf 1", acc16, ovf16); end
    endtask

    task automatic test_handshake();
        qa = '{2, 2, 2, 2};
        qb = '{3, 3, 3, 3};
        do_burst("handshake", 1, 3, 5);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int n;
            n  = $urandom_range(20, 1);
            qa = {};
            qb = {};
            for (int i = 0; i < n; i++) begin
                qa.push_back($urandom_range(255, 0));
                qb.push_back($urandom_range(255, 0));
            end
            do_burst("random", 0, r % 3, $urandom_range(3, 0));
        end
    endtask

    task automatic test_control();
        longint sum;
        int     pa[4];
        int     pb[4];
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            pa[i] = $urandom_range(255, 0);
            pb[i] = $urandom_range(255, 0);
            sum += longint'(pa[i]) * longint'(pb[i]);
        end
        start = 1'b1; len = 8'd4; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = pa[i][7:0]; b = pb[i][7:0]; step();
        end
        in_valid = 1'b0;
        start = 1'b1; len = 8'd9; step(); start = 1'b0;
        checks++; if (in_ready24 !== 1'b1 || busy24 !== 1'b1) begin errors++; $display("FAIL ctl stray start: got ir=%b busy=%b want 1 1", in_ready24, busy24); end
        for (int i = 2; i < 4; i++) begin
            in_valid = 1'b1; a = pa[i][7:0]; b = pb[i][7:0]; step();
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid24 !== 1'b1 || acc24 !== sum[23:0]) begin errors++; $display("FAIL ctl count kept: got ov=%b acc=%0d want 1 %0d", out_valid24, acc24, sum[23:0]); end
        out_ready = 1'b1; step(); out_ready = 1'b0;

        start = 1'b1; len = 8'd3; step(); start = 1'b0;
        in_valid = 1'b1; a = 8'd200; b = 8'd200; step();
        in_valid = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        checks++; if (in_ready24 !== 1'b0 || out_valid24 !== 1'b0 || busy24 !== 1'b0 || acc24 !== 24'd0 || ovf24 !== 1'b0) begin errors++; $display("FAIL ctl mid reset: got ir=%b ov=%b busy=%b acc=%0d ovf=%b want all 0", in_ready24, out_valid24, busy24, acc24, ovf24); end
        checks++; if (busy16 !== 1'b0 || acc16 !== 16'd0) begin errors++; $display("FAIL ctl mid reset16: got busy=%b acc=%0d want 0 0", busy16, acc16); end
        step();
        qa = '{10};
        qb = '{10};
        do_burst("after_reset", 0, 0, 0);
        checks++; if (acc24 !== 24'd100) begin errors++; $display("FAIL after_reset const: got %0d want 100", acc24); end
    endtask

    task automatic test_sweep();
        qa = {};
        qb = {};
        for (int i = 0; i < 255; i++) begin
            qa.push_back(i);
            qb.push_back(255 - i);
        end
        do_burst("sweep", 0, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_handshake();
        test_back_to_back();
        test_control();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
